// File: rtl/soduku_controller.sv
// soduku_controller: captures a puzzle, loads it into soduku_solver, and reports solved/stuck/timeout; start is ignored while busy.
// Define SODUKU_CTRL_CHECK_EN to insert a 27-cycle row/column/square validity scan between solve detection and DONE.
module soduku_controller #(
    parameter int GRID_SIZE     = 9,
    parameter int STABLE_CYCLES = 4,
    parameter int MAX_CYCLES    = 1023,
    parameter int CNT_W         = 10
) (
    input  logic                             clk_in,
    input  logic                             reset_in,
    input  logic                             start_in,
    input  logic                             abort_in,
    input  logic [4*GRID_SIZE*GRID_SIZE-1:0] board_in,
    input  logic [4*GRID_SIZE*GRID_SIZE-1:0] solver_board_in,
    output logic                             solver_reset_out,
    output logic [4*GRID_SIZE*GRID_SIZE-1:0] solver_board_out,
    output logic                             busy_out,
    output logic                             done_out,
    output logic                             solved_out,
    output logic                             stuck_out,
    output logic                             timeout_out,
    output logic                             valid_out,
    output logic [CNT_W-1:0]                 iterations_out,
    output logic [4*GRID_SIZE*GRID_SIZE-1:0] board_out
);
    localparam int CELLS = GRID_SIZE * GRID_SIZE;
    localparam int SW    = $clog2(STABLE_CYCLES + 1);

`ifdef SODUKU_CTRL_CHECK_EN
    typedef enum logic [2:0] {IDLE, LOAD, RUN, CHECK, DONE} state_t;
    localparam state_t SOLVE_NXT = CHECK;
`else
    typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE} state_t;
    localparam state_t SOLVE_NXT = DONE;
`endif

    state_t             state, state_nxt;
    logic [4*CELLS-1:0] prev_reg;
    logic [SW-1:0]      stable_cnt;
    logic               has_zero, eq, stuck_hit, timeout_hit;
    logic               load_start, do_abort;

    always_comb begin
        has_zero = 1'b0;
        for (int i = 0; i < CELLS; i++)
            if (solver_board_in[4*i +: 4] == 4'd0) has_zero = 1'b1;
    end

    assign eq          = (solver_board_in == prev_reg);
    assign stuck_hit   = eq && (stable_cnt == SW'(STABLE_CYCLES - 1));
    assign timeout_hit = (iterations_out == CNT_W'(MAX_CYCLES - 1));
    assign busy_out    = (state != IDLE) && (state != DONE);
    assign done_out    = (state == DONE);
    assign load_start  = start_in && !busy_out;
    assign do_abort    = abort_in && busy_out;

`ifdef SODUKU_CTRL_CHECK_EN
    logic [4:0] grp_idx;
    logic       check_err;
    logic [8:0] grp_mask;
    logic [3:0] nib;

    // Cell index of member k of group g: rows 0..8, then columns 0..8, then 3x3 squares 0..8.
    function automatic int group_cell(input int g, input int k);
        int r, c;
        if (g < 9) begin
            r = g;
            c = k;
        end else if (g < 18) begin
            r = k;
            c = g - 9;
        end else begin
            r = ((g - 18) / 3) * 3 + k / 3;
            c = ((g - 18) % 3) * 3 + k % 3;
        end
        return r * GRID_SIZE + c;
    endfunction

    always_comb begin
        grp_mask = '0;
        nib      = '0;
        for (int k = 0; k < 9; k++) begin
            nib = board_out[4*(CELLS-1-group_cell(int'(grp_idx), k)) +: 4];
            if (nib != 4'd0 && nib <= 4'd9) grp_mask = grp_mask | (9'd1 << (nib - 4'd1));
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        if (do_abort) begin
            state_nxt = IDLE;
        end else if (load_start) begin
            state_nxt = LOAD;
        end else begin
            case (state)
                LOAD: state_nxt = RUN;
                RUN: begin
                    if (!has_zero)                      state_nxt = SOLVE_NXT;
                    else if (stuck_hit || timeout_hit) state_nxt = DONE;
                end
`ifdef SODUKU_CTRL_CHECK_EN
                CHECK: if (grp_idx == 5'd26) state_nxt = DONE;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            solver_reset_out <= 1'b1;
            solver_board_out <= '0;
            prev_reg         <= '0;
            stable_cnt       <= '0;
            iterations_out   <= '0;
            board_out        <= '0;
            solved_out       <= 1'b0;
            stuck_out        <= 1'b0;
            timeout_out      <= 1'b0;
            valid_out        <= 1'b0;
`ifdef SODUKU_CTRL_CHECK_EN
            grp_idx          <= '0;
            check_err        <= 1'b0;
`endif
        end else begin
            // Abort and start both park the solver and clear the status; board_out survives an abort.
            if (load_start || do_abort) begin
                solver_reset_out <= 1'b1;
                solved_out       <= 1'b0;
                stuck_out        <= 1'b0;
                timeout_out      <= 1'b0;
                valid_out        <= 1'b0;
            end
            if (load_start) begin
                solver_board_out <= board_in;
                iterations_out   <= '0;
                stable_cnt       <= '0;
            end else if (!do_abort) begin
                case (state)
                    LOAD: begin
                        prev_reg         <= solver_board_out;
                        solver_reset_out <= 1'b0;
                    end
                    RUN: begin
                        iterations_out <= iterations_out + 1'b1;
                        prev_reg       <= solver_board_in;
                        stable_cnt     <= eq ? stable_cnt + 1'b1 : '0;
                        if (!has_zero || stuck_hit || timeout_hit) board_out <= solver_board_in;
                        if (!has_zero) begin
                            solved_out <= 1'b1;
`ifdef SODUKU_CTRL_CHECK_EN
                            grp_idx    <= '0;
                            check_err  <= 1'b0;
`else
                            valid_out  <= 1'b1;
`endif
                        end else if (stuck_hit) begin
                            stuck_out <= 1'b1;
                        end else if (timeout_hit) begin
                            timeout_out <= 1'b1;
                        end
                    end
`ifdef SODUKU_CTRL_CHECK_EN
                    CHECK: begin
                        grp_idx <= grp_idx + 1'b1;
                        if (grp_mask != 9'h1FF) check_err <= 1'b1;
                        if (grp_idx == 5'd26) valid_out <= !check_err && (grp_mask == 9'h1FF);
                    end
`endif
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_soduku_controller.sv
// Scoreboard bench for soduku_controller: a behavioural solver stub (fill / stall / churn) drives solver_board_in,
// and a run-level outcome model predicts each run's final status, board, iteration count and latency.
module tb_soduku_controller;
    localparam int STABLE = 4;
    localparam int MAXC   = 40;
    localparam int CW     = 10;
    localparam int INF    = 1 << 30;
`ifdef SODUKU_CTRL_CHECK_EN
    localparam int CHK_LAT = 27;
    localparam bit CHK_ON  = 1'b1;
`else
    localparam int CHK_LAT = 0;
    localparam bit CHK_ON  = 1'b0;
`endif

    typedef struct packed {
        logic         solved;
        logic         stuck;
        logic         tmo;
        logic         valid;
        int           iters;
        int           lat;
        int           start_cyc;
        logic [323:0] board;
    } exp_t;

    logic           clk_in = 1'b0;
    logic           reset_in, start_in, abort_in;
    logic [323:0]   board_in, solver_board_in, solver_board_out, board_out;
    logic           solver_reset_out, busy_out, done_out, solved_out, stuck_out, timeout_out, valid_out;
    logic [CW-1:0]  iterations_out;

    int             n_checks = 0;
    int             n_pass   = 0;
    int             cyc      = 0;
    int             hidden [81];
    int             stub_mode, stub_limit, stub_fills, churn_cell;
    exp_t           sb_q [$];
    exp_t           mon_e;
    logic           done_q = 1'b0;
    logic [323:0]   last_board = '0;
    logic [323:0]   puz;

    soduku_controller #(.GRID_SIZE(9), .STABLE_CYCLES(STABLE), .MAX_CYCLES(MAXC), .CNT_W(CW)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .start_in(start_in), .abort_in(abort_in),
        .board_in(board_in), .solver_board_in(solver_board_in),
        .solver_reset_out(solver_reset_out), .solver_board_out(solver_board_out),
        .busy_out(busy_out), .done_out(done_out), .solved_out(solved_out), .stuck_out(stuck_out),
        .timeout_out(timeout_out), .valid_out(valid_out), .iterations_out(iterations_out),
        .board_out(board_out)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic logic [3:0] cell_of(input logic [323:0] b, input int i);
        return b[4*(80-i) +: 4];
    endfunction

    function automatic int first_zero(input logic [323:0] b);
        for (int i = 0; i < 81; i++)
            if (cell_of(b, i) == 4'd0) return i;
        return -1;
    endfunction

    // Solver stub: load while held in reset, then fill one empty cell per cycle up to a limit, or churn one cell.
    always @(posedge clk_in) begin
        if (solver_reset_out) begin
            solver_board_in <= solver_board_out;
            stub_fills      <= 0;
        end else if (stub_mode == 1) begin
            solver_board_in[4*(80-churn_cell) +: 4] <= (solver_board_in[4*(80-churn_cell) +: 4] % 4'd9) + 4'd1;
        end else if (stub_fills < stub_limit && first_zero(solver_board_in) >= 0) begin
            solver_board_in[4*(80-first_zero(solver_board_in)) +: 4] <= 4'(hidden[first_zero(solver_board_in)]);
            stub_fills <= stub_fills + 1;
        end
    end

    task automatic check(input string name, input logic [323:0] act, input logic [323:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Every row, column and square holds each digit 1..9 exactly once.
    function automatic bit sudoku_ok(input logic [323:0] b);
        int n;
        bit in_u;
        for (int u = 0; u < 27; u++)
            for (int d = 1; d <= 9; d++) begin
                n = 0;
                for (int r = 0; r < 9; r++)
                    for (int c = 0; c < 9; c++) begin
                        in_u = (u < 9) ? (r == u) : (u < 18) ? (c == u - 9) : ((r / 3) * 3 + c / 3 == u - 18);
                        if (in_u && int'(cell_of(b, r * 9 + c)) == d) n++;
                    end
                if (n != 1) return 1'b0;
            end
        return 1'b1;
    endfunction

    // Outcome of a whole run: RUN edge t sees the loaded board plus (t-1) stub steps.
    function automatic exp_t predict(input logic [323:0] p, input int mode, input int limit, input int cc);
        exp_t e;
        int z, f, ts, tk, texit, k, v;
        logic [323:0] b;
        z = 0;
        for (int i = 0; i < 81; i++) if (cell_of(p, i) == 4'd0) z++;
        if (mode == 0) begin
            f  = (limit < z) ? limit : z;
            ts = (f == z) ? z + 1 : INF;
            tk = (f == 0) ? STABLE : f + STABLE + 1;
        end else begin
            f  = 0;
            ts = (z == 0) ? 1 : INF;
            tk = INF;
        end
        texit = MAXC;
        if (tk < texit) texit = tk;
        if (ts < texit) texit = ts;
        b = p;
        if (mode == 0) begin
            k = (texit - 1 < f) ? texit - 1 : f;
            for (int i = 0; i < 81; i++)
                if (k > 0 && cell_of(b, i) == 4'd0) begin
                    b[4*(80-i) +: 4] = 4'(hidden[i]);
                    k--;
                end
        end else begin
            v = int'(cell_of(p, cc));
            b[4*(80-cc) +: 4] = 4'(((v - 1 + texit - 1) % 9) + 1);
        end
        e.solved    = (ts == texit);
        e.stuck     = !e.solved && (tk == texit);
        e.tmo       = !e.solved && !e.stuck;
        e.valid     = e.solved && (CHK_ON ? sudoku_ok(b) : 1'b1);
        e.iters     = texit;
        e.lat       = texit + 1 + (e.solved ? CHK_LAT : 0);
        e.start_cyc = 0;
        e.board     = b;
        return e;
    endfunction

    task automatic make_hidden(input bit corrupt);
        int perm [9];
        int j, t;
        for (int i = 0; i < 9; i++) perm[i] = i + 1;
        for (int i = 8; i > 0; i--) begin
            j = $urandom_range(i);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++) hidden[r*9+c] = perm[(r * 3 + r / 3 + c) % 9];
        if (corrupt) begin
            if (hidden[36] == 5) hidden[37] = 5;
            else hidden[36] = 5;
        end
    endtask

    function automatic logic [323:0] make_puzzle(input int nblank);
        logic [323:0] b;
        for (int i = 0; i < 81; i++) b[4*(80-i) +: 4] = 4'(hidden[i]);
        for (int j = 0; j < nblank; j++) b[4*(80-$urandom_range(80)) +: 4] = 4'd0;
        return b;
    endfunction

    task automatic run_start(input logic [323:0] p, input int mode, input int limit, input int cc, input bit track);
        exp_t e;
        e = predict(p, mode, limit, cc);
        stub_mode = mode; stub_limit = limit; churn_cell = cc;
        board_in = p;
        start_in = 1'b1;
        @(posedge clk_in); #1;
        start_in = 1'b0;
        e.start_cyc = cyc;
        if (track) begin
            sb_q.push_back(e);
            last_board = e.board;
        end
    endtask

    task automatic wait_q();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            @(negedge clk_in);
            n++;
        end
        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else begin
            $display("FAIL run_wait: %0d runs never reached DONE, 0 expected", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic random_run();
        int mode, nb, lim, cc;
        logic [323:0] p;
        make_hidden($urandom_range(3) == 0);
        nb   = $urandom_range(50);
        p    = make_puzzle(nb);
        mode = ($urandom_range(3) == 0) ? 1 : 0;
        lim  = ($urandom_range(1) == 1) ? 100 : $urandom_range(nb);
        cc   = $urandom_range(80);
        if (mode == 1) p[4*(80-cc) +: 4] = 4'(hidden[cc]);
        run_start(p, mode, lim, cc, 1'b1);
        wait_q();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_solver_reset"}, solver_reset_out, 1);
        check({tag, "_flags"}, {busy_out, done_out, solved_out, stuck_out, timeout_out, valid_out}, 0);
        check({tag, "_iterations"}, iterations_out, 0);
        check({tag, "_board_out"}, board_out, 0);
        check({tag, "_solver_board"}, solver_board_out, 0);
    endtask

    // Monitor: each rising done_out retires the oldest outstanding run.
    always @(negedge clk_in) begin
        if (done_out && !done_q) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: done_out rose with no run outstanding");
            end else begin
                mon_e = sb_q.pop_front();
                check("status{solved,stuck,timeout,valid}", {solved_out, stuck_out, timeout_out, valid_out},
                      {mon_e.solved, mon_e.stuck, mon_e.tmo, mon_e.valid});
                check("iterations", iterations_out, mon_e.iters);
                check("final_board", board_out, mon_e.board);
                check("start_to_done_edges", cyc - mon_e.start_cyc, mon_e.lat);
                check("busy_in_done", busy_out, 0);
            end
        end
        done_q <= done_out;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        reset_in = 1'b1; start_in = 1'b0; abort_in = 1'b0; board_in = '0;
        stub_mode = 0; stub_limit = 0; churn_cell = 0;
        repeat (3) @(posedge clk_in);
        #1 check_reset_vals("reset");
        @(negedge clk_in) reset_in = 1'b0;
        @(posedge clk_in); #1;
        check_reset_vals("idle");

        // Already-complete board: one RUN edge, solver reset high only in LOAD.
        make_hidden(1'b0);
        run_start(make_puzzle(0), 0, 100, 0, 1'b1);
        check("load_busy", busy_out, 1);
        check("load_solver_reset", solver_reset_out, 1);
        @(posedge clk_in); #1;
        check("run_solver_reset", solver_reset_out, 0);
        wait_q();

        // Singleton-solvable puzzle, with a start pulse during RUN that must be ignored.
        make_hidden(1'b0);
        puz = make_puzzle(30);
        run_start(puz, 0, 100, 0, 1'b1);
        repeat (2) @(posedge clk_in);
        #1 board_in = '0; start_in = 1'b1;
        @(posedge clk_in); #1;
        start_in = 1'b0;
        check("start_during_run_ignored", solver_board_out, puz);
        wait_q();

        // Stalling solver -> stuck; churning solver -> timeout; full board with duplicate 5 in row 4.
        make_hidden(1'b0);
        run_start(make_puzzle(30), 0, 8, 0, 1'b1);
        wait_q();
        make_hidden(1'b0);
        puz = make_puzzle(20);
        puz[4*(80-40) +: 4] = 4'(hidden[40]);
        run_start(puz, 1, 0, 40, 1'b1);
        wait_q();
        make_hidden(1'b1);
        run_start(make_puzzle(0), 0, 100, 0, 1'b1);
        wait_q();

        // Abort on the third RUN edge.
        make_hidden(1'b0);
        run_start(make_puzzle(45), 0, 100, 0, 1'b0);
        repeat (3) @(posedge clk_in);
        #1 abort_in = 1'b1;
        @(posedge clk_in); #1;
        abort_in = 1'b0;
        check("abort_busy", busy_out, 0);
        check("abort_solver_reset", solver_reset_out, 1);
        check("abort_flags", {done_out, solved_out, stuck_out, timeout_out, valid_out}, 0);
        check("abort_board_out_kept", board_out, last_board);
        random_run();

        for (int it = 0; it < 20; it++) random_run();

        // Asynchronous reset in the middle of RUN.
        make_hidden(1'b0);
        run_start(make_puzzle(40), 0, 100, 0, 1'b0);
        repeat (3) @(posedge clk_in);
        @(negedge clk_in) reset_in = 1'b1;
        #1 check_reset_vals("midrun_reset");
        @(negedge clk_in) reset_in = 1'b0;
        random_run();

        repeat (3) @(posedge clk_in);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
